// File: rtl/crc_stream_append.sv
// Streaming CRC generator for the transmit path: forwards payload beats with
// one cycle of latency, folds each beat into the CRC as it passes, then appends
// the finished CRC as CRC_W/DATA_W extra beats, MSB first.
module crc_stream_append #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = 32'h973afb51,
  parameter logic [CRC_W-1:0] INIT   = '1,
  parameter logic [CRC_W-1:0] XOROUT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_done,
  output logic              abort
);

  localparam int             N   = CRC_W / DATA_W;
  localparam int             CW  = $clog2(N + 1);
  localparam logic [CW-1:0]  N_L = CW'(N);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_APPEND} state_t;

  state_t              r_state, w_state_nxt;
  logic [CRC_W-1:0]    r_crc, r_shift, r_crc_value;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid, r_out_first, r_out_last, r_done, r_abort;
  logic [CRC_W-1:0]    w_seed, w_crc_nxt, w_fin;
  logic                w_out_free, w_fwd, w_end, w_emit, w_app_done, w_abort;

  // Bit-serial CRC over one beat, MSB first, non-reflected; unrolls to XOR trees.
  function automatic logic [CRC_W-1:0] f_crc(input logic [CRC_W-1:0] c,
                                             input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  // A beat carrying in_first always restarts from INIT, even mid-frame.
  assign w_seed     = in_first ? INIT : r_crc;
  assign w_crc_nxt  = f_crc(w_seed, in_data);
  assign w_fin      = w_crc_nxt ^ XOROUT;
  assign w_out_free = !r_out_valid | out_ready;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_fwd       = 1'b0;
    w_end       = 1'b0;
    w_emit      = 1'b0;
    w_app_done  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE, S_PASS: begin
        in_ready = !rst & w_out_free;
        if (in_valid & in_ready) begin
          if (in_first) begin
            w_fwd       = 1'b1;
            w_abort     = (r_state == S_PASS);
            w_state_nxt = S_PASS;
          end else if (r_state == S_PASS) begin
            w_fwd = 1'b1;
          end
          // Non-first beats in IDLE fall through here and are dropped.
          if (w_fwd & in_last) begin
            w_end       = 1'b1;
            w_state_nxt = S_APPEND;
          end
        end
      end
      S_APPEND: begin
        w_emit = w_out_free & (r_cnt != N_L);
        if (r_out_valid & out_ready & r_out_last) begin
          w_app_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Running CRC, CRC shift-out register and beat counter, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc       <= INIT;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_crc_value <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done  <= w_end;
      r_abort <= w_abort;
      if (w_fwd)           r_crc <= w_crc_nxt;
      else if (w_app_done) r_crc <= INIT;
      if (w_end) begin
        r_shift     <= w_fin;
        r_cnt       <= '0;
        r_crc_value <= w_fin;
      end else if (w_emit) begin
        r_shift <= r_shift << DATA_W;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  // Single output register; holds while stalled, drains to empty when free and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_fwd) begin
      r_out_data  <= in_data;
      r_out_valid <= 1'b1;
      r_out_first <= in_first;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_data  <= r_shift[CRC_W-1 -: DATA_W];
      r_out_valid <= 1'b1;
      r_out_first <= 1'b0;
      r_out_last  <= (r_cnt == N_L - CW'(1));
    end else if (w_out_free) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign crc_value = r_crc_value;
  assign crc_done  = r_done;
  assign abort     = r_abort;

endmodule

// File: tb/tb_crc_stream_append.sv
// Directed bench: CRC-32/MPEG-2 (with and without XOROUT), CRC-16/CCITT,
// random backpressure, mid-frame restart and reset during the CRC tail.
module tb_crc_stream_append;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid_a = 1'b0, in_valid_c = 1'b0;
  logic        in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_first, a_out_last, a_crc_done, a_abort;
  logic [7:0]  a_out_data;
  logic [31:0] a_crc_value;
  logic        b_in_ready, b_out_valid, b_out_first, b_out_last, b_crc_done, b_abort;
  logic [7:0]  b_out_data;
  logic [31:0] b_crc_value;
  logic        c_in_ready, c_out_valid, c_out_first, c_out_last, c_crc_done, c_abort;
  logic [7:0]  c_out_data;
  logic [15:0] c_crc_value;

  always #5 clk = ~clk;

  crc_stream_append #(.DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7),
    .INIT(32'hFFFFFFFF), .XOROUT(32'h00000000)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
    .in_first(in_first), .in_last(in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_first(a_out_first),
    .out_last(a_out_last), .out_ready(out_ready), .crc_value(a_crc_value),
    .crc_done(a_crc_done), .abort(a_abort));

  crc_stream_append #(.DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7),
    .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
    .in_first(in_first), .in_last(in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_first(b_out_first),
    .out_last(b_out_last), .out_ready(out_ready), .crc_value(b_crc_value),
    .crc_done(b_crc_done), .abort(b_abort));

  crc_stream_append #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021),
    .INIT(16'hFFFF), .XOROUT(16'h0000)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_c),
    .in_first(in_first), .in_last(in_last), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_first(c_out_first),
    .out_last(c_out_last), .out_ready(out_ready), .crc_value(c_crc_value),
    .crc_done(c_crc_done), .abort(c_abort));

  int          n_tot = 0, n_bad = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;
  int          na_last = 0, nc_last = 0, n_abort = 0, n_bdone = 0;
  int          stall_bad = 0, app_bad = 0;
  logic        rnd = 1'b0, t6_arm = 1'b0, t6_hit = 1'b0;
  logic [9:0]  qa[$], qb[$], qc[$], exp_q[$];
  logic [7:0]  s9[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor at the falling edge: records beats that will transfer on the next rising edge.
  initial begin
    logic       prev_stall, in_app;
    logic [9:0] prev_beat, cur;
    prev_stall = 1'b0;
    in_app     = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (t6_arm && qa.size() == 11) begin
        out_ready = 1'b0;
        rst       = 1'b1;
        t6_arm    = 1'b0;
        t6_hit    = 1'b1;
      end
      if (rst) begin
        prev_stall = 1'b0;
        in_app     = 1'b0;
      end else begin
        cur = {a_out_first, a_out_last, a_out_data};
        if (a_out_valid && out_ready) qa.push_back(cur);
        if (b_out_valid && out_ready) qb.push_back({b_out_first, b_out_last, b_out_data});
        if (c_out_valid && out_ready) qc.push_back({c_out_first, c_out_last, c_out_data});
        if (a_out_valid && out_ready && a_out_last) na_last++;
        if (c_out_valid && out_ready && c_out_last) nc_last++;
        if (a_abort) n_abort++;
        if (b_crc_done) begin
          n_bdone++;
          done_cyc = cyc;
        end
        if (in_valid_a && b_in_ready && in_last) acc_cyc = cyc;
        if (prev_stall && !(a_out_valid && cur == prev_beat)) stall_bad++;
        prev_stall = a_out_valid && !out_ready;
        prev_beat  = cur;
        if (in_app && a_in_ready) app_bad++;
        if (in_valid_a && a_in_ready && in_last) in_app = 1'b1;
        if (a_out_valid && out_ready && a_out_last) in_app = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic f, input logic l, input logic sel_c);
    logic acc;
    int   k;
    in_data  = d;
    in_first = f;
    in_last  = l;
    if (sel_c) in_valid_c = 1'b1;
    else       in_valid_a = 1'b1;
    acc = 1'b0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = sel_c ? c_in_ready : a_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_tot++;
      n_bad++;
      $display("FAIL send_timeout data=%h", d);
    end
  endtask

  task automatic idle();
    in_valid_a = 1'b0;
    in_valid_c = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic send_str(input logic sel_c);
    for (int i = 0; i < 9; i++) send(s9[i], i == 0, i == 8, sel_c);
    idle();
  endtask

  task automatic wait_last(input logic sel_c, input int target);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((sel_c ? nc_last : na_last) >= target) break;
    end
    chk("frame_end_seen", 32'((sel_c ? nc_last : na_last) >= target), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Expected frame: "123456789" payload, then nb CRC bytes MSB first.
  task automatic exp_frame(input logic [31:0] crc, input int nb);
    logic [31:0] t;
    for (int i = 0; i < 9; i++) exp_q.push_back({i == 0, 1'b0, s9[i]});
    for (int j = 0; j < nb; j++) begin
      t = crc >> (8 * (nb - 1 - j));
      exp_q.push_back({1'b0, j == nb - 1, t[7:0]});
    end
  endtask

  task automatic cmp_q(input string tag, input logic [9:0] got[$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(a_in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data), 32'd0);
    chk("rst_crc_value", 32'(a_crc_value), 32'd0);
    chk("rst_crc_done",  32'(a_crc_done), 32'd0);
    chk("rst_abort",     32'(a_abort), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 + T2: same stimulus into the XOROUT=0 and XOROUT=all-ones instances.
    n_bdone = 0;
    send_str(1'b0);
    wait_last(1'b0, 1);
    exp_q.delete();
    exp_frame(32'h0376E6E7, 4);
    cmp_q("t1", qa);
    chk("t1_crc_value", a_crc_value, 32'h0376E6E7);
    exp_q.delete();
    exp_frame(32'hFC891918, 4);
    cmp_q("t2", qb);
    chk("t2_crc_value", b_crc_value, 32'hFC891918);
    chk("t2_done_width", 32'(n_bdone), 32'd1);
    chk("t2_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

    // T3: 16-bit CRC.
    qc.delete();
    send_str(1'b1);
    wait_last(1'b1, 1);
    exp_q.delete();
    exp_frame(32'h000029B1, 2);
    cmp_q("t3", qc);
    chk("t3_crc_value", 32'(c_crc_value), 32'h000029B1);

    // T4: random backpressure.
    qa.delete();
    na_last = 0;
    stall_bad = 0;
    app_bad = 0;
    rnd = 1'b1;
    send_str(1'b0);
    wait_last(1'b0, 1);
    rnd = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    exp_frame(32'h0376E6E7, 4);
    cmp_q("t4", qa);
    chk("t4_stall_hold", 32'(stall_bad), 32'd0);
    chk("t4_append_ready", 32'(app_bad), 32'd0);

    // T5: partial frame restarted by a new in_first.
    @(posedge clk);
    #1;
    qa.delete();
    na_last = 0;
    n_abort = 0;
    send(8'hAA, 1'b1, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0, 1'b0);
    send_str(1'b0);
    wait_last(1'b0, 1);
    exp_q.delete();
    exp_q.push_back({2'b10, 8'hAA});
    exp_q.push_back({2'b00, 8'hBB});
    exp_q.push_back({2'b00, 8'hCC});
    exp_frame(32'h0376E6E7, 4);
    cmp_q("t5", qa);
    chk("t5_abort_cnt", 32'(n_abort), 32'd1);
    chk("t5_crc_value", a_crc_value, 32'h0376E6E7);

    // T6: reset after two CRC beats have transferred.
    qa.delete();
    na_last = 0;
    t6_hit = 1'b0;
    t6_arm = 1'b1;
    send_str(1'b0);
    for (int k = 0; k < 200 && !t6_hit; k++) @(negedge clk);
    chk("t6_reset_hit", 32'(t6_hit), 32'd1);
    if (!t6_hit) begin
      t6_arm = 1'b0;
      rst = 1'b1;
    end
    @(negedge clk);
    chk("t6_out_valid", 32'(a_out_valid), 32'd0);
    chk("t6_crc_value", a_crc_value, 32'd0);
    chk("t6_in_ready", 32'(a_in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    na_last = 0;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_drop_nout", 32'(qa.size()), 32'd0);
    send_str(1'b0);
    wait_last(1'b0, 1);
    exp_q.delete();
    exp_frame(32'h0376E6E7, 4);
    cmp_q("t6", qa);
    chk("t6_crc_after", a_crc_value, 32'h0376E6E7);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
